// File: rtl/exp_arbiter.sv
// exp_arbiter: shares one exponential unit between two requesters.
// Round-robin grant among eligible requesters (request pending and result
// buffer empty), one-cycle launch, then wait for exp_done with a timeout.
// Ports:
//   clk, rst (async, active-low)
//   req0/req1, x0/x1            : requests and 16-bit operands
//   gnt0/gnt1                   : one-cycle operand-accepted pulses
//   rvalid0/rvalid1, rready0/1  : per-requester result buffer handshake
//   res*_int [1:0], res*_frac   : buffered results
//   exp_start, exp_x            : launch of the shared exponential unit
//   exp_done, exp_int, exp_frac : return from the exponential unit
//   busy                        : not idle
//   timeout_err, to_id          : abort pulse and aborted requester index
module exp_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  input  logic        rready0,
  input  logic        rready1,
  output logic [1:0]  res0_int,
  output logic [1:0]  res1_int,
  output logic [15:0] res0_frac,
  output logic [15:0] res1_frac,
  output logic        exp_start,
  output logic [15:0] exp_x,
  input  logic        exp_done,
  input  logic [1:0]  exp_int,
  input  logic [15:0] exp_frac,
  output logic        busy,
  output logic        timeout_err,
  output logic        to_id
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t             state_q, state_n;
  logic               owner_q, owner_n;
  logic               last_q, last_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [15:0]        exp_x_q, exp_x_n;
  logic               exp_start_q, exp_start_n;
  logic               gnt0_q, gnt0_n, gnt1_q, gnt1_n;
  logic               rvalid0_q, rvalid0_n, rvalid1_q, rvalid1_n;
  logic [17:0]        res0_q, res0_n, res1_q, res1_n;
  logic               busy_q, busy_n;
  logic               tout_q, tout_n;
  logic               to_id_q, to_id_n;
  logic               elig0, elig1, pick;

  // Eligibility uses the registered buffer flag, so a buffer being drained
  // on this edge only becomes eligible on the following edge.
  assign elig0 = req0 & ~rvalid0_q;
  assign elig1 = req1 & ~rvalid1_q;

  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    last_n      = last_q;
    cnt_n       = cnt_q;
    exp_x_n     = exp_x_q;
    exp_start_n = 1'b0;
    gnt0_n      = 1'b0;
    gnt1_n      = 1'b0;
    tout_n      = 1'b0;
    to_id_n     = to_id_q;
    rvalid0_n   = rvalid0_q & ~rready0;
    rvalid1_n   = rvalid1_q & ~rready1;
    res0_n      = res0_q;
    res1_n      = res1_q;
    pick        = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          // Tie goes to the requester not granted last time.
          pick        = (elig0 & elig1) ? ~last_q : elig1;
          owner_n     = pick;
          last_n      = pick;
          exp_x_n     = pick ? x1 : x0;
          exp_start_n = 1'b1;
          gnt0_n      = ~pick;
          gnt1_n      = pick;
          state_n     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // Done takes priority over a timeout expiring on the same edge.
        if (exp_done) begin
          if (owner_q) begin
            res1_n    = {exp_int, exp_frac};
            rvalid1_n = 1'b1;
          end else begin
            res0_n    = {exp_int, exp_frac};
            rvalid0_n = 1'b1;
          end
          state_n = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tout_n  = 1'b1;
          to_id_n = owner_q;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      exp_x_q     <= '0;
      exp_start_q <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      res0_q      <= '0;
      res1_q      <= '0;
      busy_q      <= 1'b0;
      tout_q      <= 1'b0;
      to_id_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      owner_q     <= owner_n;
      last_q      <= last_n;
      cnt_q       <= cnt_n;
      exp_x_q     <= exp_x_n;
      exp_start_q <= exp_start_n;
      gnt0_q      <= gnt0_n;
      gnt1_q      <= gnt1_n;
      rvalid0_q   <= rvalid0_n;
      rvalid1_q   <= rvalid1_n;
      res0_q      <= res0_n;
      res1_q      <= res1_n;
      busy_q      <= busy_n;
      tout_q      <= tout_n;
      to_id_q     <= to_id_n;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign res0_int    = res0_q[17:16];
  assign res0_frac   = res0_q[15:0];
  assign res1_int    = res1_q[17:16];
  assign res1_frac   = res1_q[15:0];
  assign exp_start   = exp_start_q;
  assign exp_x       = exp_x_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;
  assign to_id       = to_id_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed bench for exp_arbiter with a small exponential-unit model:
// done follows exp_start by a programmable number of cycles and returns
// int = x[1:0]^1, frac = 3*x + 0x1234.
module tb_exp_arbiter;

  logic        clk, rst;
  logic        req0, req1, rready0, rready1;
  logic [15:0] x0, x1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [1:0]  res0_int, res1_int;
  logic [15:0] res0_frac, res1_frac;
  logic        exp_start, exp_done, busy, timeout_err, to_id;
  logic [15:0] exp_x, exp_frac;
  logic [1:0]  exp_int;

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b1;
  int model_lat = 6;

  exp_arbiter #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .x0(x0), .x1(x1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rready0(rready0), .rready1(rready1),
    .res0_int(res0_int), .res1_int(res1_int),
    .res0_frac(res0_frac), .res1_frac(res1_frac),
    .exp_start(exp_start), .exp_x(exp_x),
    .exp_done(exp_done), .exp_int(exp_int), .exp_frac(exp_frac),
    .busy(busy), .timeout_err(timeout_err), .to_id(to_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Exponential unit model, updated on the falling edge.
  initial begin
    bit          active;
    int          mc;
    logic [15:0] mx;
    active   = 1'b0;
    mc       = 0;
    mx       = '0;
    exp_done = 1'b0;
    exp_int  = '0;
    exp_frac = '0;
    forever begin
      @(negedge clk);
      exp_done = 1'b0;
      if (exp_start) begin
        active = 1'b1;
        mc     = 0;
        mx     = exp_x;
      end else if (active) begin
        mc++;
        if (mc >= model_lat) begin
          active = 1'b0;
          if (model_en) begin
            exp_done = 1'b1;
            exp_int  = mx[1:0] ^ 2'b01;
            exp_frac = 16'(mx * 16'd3 + 16'h1234);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; x0 = '0; x1 = '0;
    rready0 = 1'b1; rready1 = 1'b1;

    // Reset state
    tick();
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_start", 32'(exp_start), 0);
    chk("rst_x", 32'(exp_x), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
    chk("rst_tout", 32'({timeout_err, to_id}), 0);

    // Tie right after release: requester 0 first, then alternate 0,1,0,1
    #3;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; x0 = 16'd1; x1 = 16'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", 32'(gnt1), (i % 2 == 1) ? 1 : 0);
      chk("rr_start", 32'(exp_start), 1);
      chk("rr_x", 32'(exp_x), (i % 2 == 0) ? 1 : 2);
      repeat (6) tick();
      chk("rr_notyet", 32'((i % 2 == 0) ? rvalid0 : rvalid1), 0);
      tick();
      if (i % 2 == 0) begin
        chk("rr_rv0", 32'(rvalid0), 1);
        chk("rr_res0", 32'({res0_int, res0_frac}), 32'h0_1237);
      end else begin
        chk("rr_rv1", 32'(rvalid1), 1);
        chk("rr_res1", 32'({res1_int, res1_frac}), 32'h3_123A);
      end
      chk("rr_busy", 32'(busy), 0);
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        tick();
      end
    end
    tick();
    chk("rr_idle", 32'({busy, gnt0, gnt1, rvalid1}), 0);

    // Single requester 0, x=10, result held (rready0=0)
    rready0 = 1'b0; req0 = 1'b1; x0 = 16'd10;
    tick();
    chk("s0_gnt", 32'({gnt0, gnt1}), 32'b10);
    chk("s0_start", 32'(exp_start), 1);
    chk("s0_x", 32'(exp_x), 10);
    tick();
    chk("s0_launch_end", 32'({gnt0, exp_start, busy}), 32'b001);
    repeat (5) tick();
    chk("s0_notyet", 32'(rvalid0), 0);
    tick();
    chk("s0_rvalid", 32'(rvalid0), 1);
    chk("s0_res", 32'({res0_int, res0_frac}), 32'h3_1252);
    chk("s0_busy", 32'(busy), 0);

    // Requester 0 held while its buffer is full; requester 1 is served
    req1 = 1'b1; x1 = 16'd7;
    tick();
    chk("blk_gnt", 32'({gnt0, gnt1}), 32'b01);
    chk("blk_x", 32'(exp_x), 7);
    req1 = 1'b0;
    repeat (6) tick();
    chk("blk_notyet1", 32'(rvalid1), 0);
    tick();
    chk("blk_rv1", 32'(rvalid1), 1);
    chk("blk_res1", 32'({res1_int, res1_frac}), 32'h2_1249);
    tick();
    chk("blk_no_gnt0", 32'({gnt0, gnt1, busy}), 0);
    chk("blk_rv0_held", 32'(rvalid0), 1);
    rready0 = 1'b1; x0 = 16'd5;
    tick();
    chk("blk_drain", 32'({rvalid0, gnt0}), 0);
    chk("blk_res0_hold", 32'(res0_frac), 32'h1252);
    tick();
    chk("blk_gnt0", 32'(gnt0), 1);
    chk("blk_x0", 32'(exp_x), 5);
    req0 = 1'b0;
    repeat (6) tick();
    tick();
    chk("blk_res0", 32'({rvalid0, res0_int, res0_frac}), 32'h4_1243);
    tick();
    chk("blk_rv0_clr", 32'(rvalid0), 0);

    // Timeout: model never answers
    model_en = 1'b0;
    req1 = 1'b1; x1 = 16'h0033;
    tick();
    chk("to_gnt1", 32'(gnt1), 1);
    req1 = 1'b0;
    tick();
    seen = 0;
    repeat (7) begin
      tick();
      if (timeout_err) seen++;
    end
    chk("to_early", 32'(seen), 0);
    tick();
    chk("to_pulse", 32'(timeout_err), 1);
    chk("to_id", 32'(to_id), 1);
    chk("to_state", 32'({busy, rvalid0, rvalid1}), 0);
    tick();
    chk("to_one_cycle", 32'(timeout_err), 0);

    // Done arriving on the final timeout count wins
    model_en = 1'b1; model_lat = 8;
    req0 = 1'b1; x0 = 16'd4;
    tick();
    chk("race_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    repeat (7) tick();
    chk("race_pre", 32'({rvalid0, timeout_err}), 0);
    tick();
    chk("race_rv0", 32'(rvalid0), 1);
    chk("race_no_tout", 32'(timeout_err), 0);
    chk("race_res", 32'({res0_int, res0_frac}), 32'h1_1240);
    tick();
    chk("race_after", 32'(timeout_err), 0);

    // Asynchronous reset mid-WAIT, late done ignored
    model_lat = 6;
    req1 = 1'b1; x1 = 16'd8;
    tick();
    chk("ar_gnt1", 32'(gnt1), 1);
    req1 = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_x", 32'(exp_x), 0);
    chk("ar_res0", 32'({res0_int, res0_frac}), 0);
    chk("ar_misc", 32'({exp_start, gnt0, gnt1, rvalid0, rvalid1, timeout_err, to_id}), 0);
    #9;
    rst = 1'b1;
    repeat (3) tick();
    chk("ar_late_done", 32'({rvalid0, rvalid1, busy}), 0);
    seen = 0;
    repeat (4) begin
      tick();
      if (timeout_err | busy) seen++;
    end
    chk("ar_quiet", 32'(seen), 0);

    // Pointer back at 1 after reset: tie goes to requester 0
    req0 = 1'b1; req1 = 1'b1; x0 = 16'd2; x1 = 16'd3;
    tick();
    chk("ar_tie_gnt", 32'({gnt0, gnt1}), 32'b10);
    chk("ar_tie_x", 32'(exp_x), 2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) tick();
    tick();
    chk("ar_res0", 32'({rvalid0, res0_int, res0_frac}), 32'h7_123A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max WAIT cycles for exp_done before abort.
REQ-002 Parameter CNT_W, default 8, width of the timeout counter; SHALL satisfy 2^CNT_W > TIMEOUT_CYC.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 req0/req1  in  1  requester n wants one exponential; held with xn until gntn.
REQ-006 x0/x1  in  16  operand of requester n.
REQ-007 gnt0/gnt1  out  1  one-cycle pulse: operand of requester n accepted.
REQ-008 rvalid0/rvalid1  out  1  result buffer n full.
REQ-009 rready0/rready1  in  1  requester n consumes result.
REQ-010 res0_int/res1_int  out  2, res0_frac/res1_frac  out  16  buffered result n.
REQ-011 exp_start  out  1, exp_x  out  16  drive of the shared exponential unit.
REQ-012 exp_done  in  1, exp_int  in  2, exp_frac  in  16  returns from the exponential unit.
REQ-013 busy  out  1  high in any state but IDLE.
REQ-014 timeout_err  out  1, to_id  out  1  one-cycle abort pulse and aborted requester index.

Function
REQ-015 FSM states IDLE, LAUNCH, WAIT; all outputs registered.
REQ-016 Requester n eligible iff reqn=1 and rvalidn=0.
REQ-017 IDLE: if any eligible, the edge latches owner, exp_x<=x_owner and enters LAUNCH; else stay.
REQ-018 Arbitration round-robin: single eligible wins; both eligible -> grant the one not last granted; last-granted pointer resets to 1 (requester 0 wins first tie).
REQ-019 LAUNCH lasts exactly one cycle with exp_start=1 and gnt_owner=1; then WAIT, counter cleared to 0.
REQ-020 exp_x SHALL stay constant from LAUNCH until return to IDLE.
REQ-021 WAIT, exp_done=1 at an edge: res_owner <= {exp_int, exp_frac}, rvalid_owner <= 1, state <= IDLE.
REQ-022 WAIT, exp_done=0: counter increments; when counter = TIMEOUT_CYC-1 at an edge: state <= IDLE, timeout_err=1 for one cycle, to_id=owner, no buffer write.
REQ-023 exp_done and final timeout count on the same edge: done wins, no timeout_err.
REQ-024 exp_done in IDLE or LAUNCH SHALL be ignored.
REQ-025 rvalidn clears on the edge where rvalidn=1 and rreadyn=1; resn holds value until next write.
REQ-026 Buffer write and clear of the same buffer on one edge cannot occur (REQ-016); other buffer's clear proceeds concurrently with a write.
REQ-027 Minimum turnaround: req sampled edge k -> gnt/exp_start cycle k+1 -> WAIT from edge k+2; done at edge m -> IDLE after m, next grant can be sampled at edge m+1.
REQ-028 req dropped before gnt: no effect unless already latched at the IDLE edge; a latched request completes normally.

Reset
REQ-029 rst=0 forces immediately: state IDLE, exp_start=0, exp_x=0, gnt0/1=0, rvalid0/1=0, res*=0, busy=0, timeout_err=0, to_id=0, counter=0, pointer=1.
REQ-030 rst asserted mid-WAIT aborts the operation; no result, no timeout_err after release.
REQ-031 First arbitration occurs on the first rising edge after rst returns to 1.

Verification (bench uses an exponential model with 6-cycle done latency unless stated)
REQ-032 req0=1, x0=16'd10 alone -> gnt0 pulse one cycle after sampling edge, exp_start one cycle with exp_x=10, rvalid0=1 with res0 = model output, gnt1 never.
REQ-033 req0=req1=1 same edge, x0=1, x1=2, rready held 1 -> grants in order 0,1,0,1 across four ops; exp_x sequence 1,2,1,2.
REQ-034 rready0=0, req0 held after first result -> no second gnt0 while rvalid0=1; req1 still served; rready0=1 then one more gnt0.
REQ-035 model never asserts done, TIMEOUT_CYC=8 -> timeout_err pulse exactly 8 cycles after LAUNCH ends, to_id=owner, rvalid unchanged, next request served.
REQ-036 rst=0 for 1 cycle mid-WAIT, asynchronous to clk -> all outputs zero immediately, late done ignored, normal operation after release.
REQ-037 done on the same edge as final timeout count -> result written, no timeout_err.
